// File: rtl/hall_pkg.sv
// Shared types and defaults for the wheel Hall-sensor conditioner.
package hall_pkg;

    typedef enum logic [0:0] {
        WAIT_FIRST,
        MEASURE
    } hall_state_e;

    localparam int unsigned FILTER_CYCLES_DEF  = 500;
    localparam int unsigned PERIOD_WIDTH_DEF   = 24;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 5_000_000;

    localparam int unsigned           GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0]   GLITCH_SAT = '1;

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser plus stability filter for the raw Hall pin;
// counts pulses that collapse before being accepted.
module hall_glitch_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hall_raw,
    output logic                hall_clean,
    output logic                rise_accept,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned   CW       = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_CYCLES);

    logic                sync1_q, sync2_q;
    logic                clean_q, clean_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    always_comb begin
        cnt_d    = cnt_q;
        clean_d  = clean_q;
        glitch_d = glitch_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == FILT_MAX) begin
                clean_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = '0;
            if (glitch_q != GLITCH_SAT) begin
                glitch_d = glitch_q + GLITCH_W'(1);
            end
        end
    end

    // Next-state view of the accepted 0->1 change; the top registers it.
    assign rise_accept = ~clean_q & clean_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            clean_q  <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            sync1_q  <= hall_raw;
            sync2_q  <= sync1_q;
            clean_q  <= clean_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign hall_clean   = clean_q;
    assign glitch_count = glitch_q;

endmodule

// File: rtl/hall_sensor_conditioner.sv
// Hall-sensor front end: filtered level, rising-edge period measurement
// and stall detection for one wheel.
module hall_sensor_conditioner
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = FILTER_CYCLES_DEF,
    parameter int unsigned PERIOD_WIDTH   = PERIOD_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hall_raw,
    output logic                    hall_clean,
    output logic                    rise_pulse,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stalled,
    output logic [GLITCH_W-1:0]     glitch_count
);

    localparam logic [PERIOD_WIDTH-1:0] TO_VAL = PERIOD_WIDTH'(TIMEOUT_CYCLES);

    logic rise_accept;

    hall_glitch_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .hall_raw    (hall_raw),
        .hall_clean  (hall_clean),
        .rise_accept (rise_accept),
        .glitch_count(glitch_count)
    );

    hall_state_e             state_q, state_d;
    logic                    rise_q;
    logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    pv_q, pv_d;
    logic                    stalled_q, stalled_d;
    logic                    timeout;

    assign pcnt_inc = pcnt_q + PERIOD_WIDTH'(1);
    assign timeout  = (pcnt_inc == TO_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_FIRST: if (rise_accept) state_d = MEASURE;
            MEASURE:    if (!rise_accept && timeout) state_d = WAIT_FIRST;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    // A rise in the same cycle as the timeout wins; stalled holds the counter at 0.
    always_comb begin
        period_d  = period_q;
        pv_d      = 1'b0;
        stalled_d = stalled_q;
        if (rise_accept) begin
            stalled_d = 1'b0;
            if (state_q == MEASURE) begin
                period_d = pcnt_inc;
                pv_d     = 1'b1;
            end
        end else if (timeout) begin
            stalled_d = 1'b1;
            if (state_q == MEASURE) begin
                period_d = '0;
            end
        end
        pcnt_d = (rise_accept || stalled_d) ? '0 : pcnt_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q    <= 1'b0;
            pcnt_q    <= '0;
            period_q  <= '0;
            pv_q      <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            rise_q    <= rise_accept;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            pv_q      <= pv_d;
            stalled_q <= stalled_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Scoreboard bench for hall_sensor_conditioner with short filter/timeout values.
module tb_hall_sensor_conditioner;

    localparam int FILT = 4;
    localparam int TO   = 100;
    localparam int PW   = 8;

    logic          clk;
    logic          reset;
    logic          hall_raw;
    logic          hall_clean;
    logic          rise_pulse;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stalled;
    logic [7:0]    glitch_count;

    hall_sensor_conditioner #(
        .FILTER_CYCLES (FILT),
        .PERIOD_WIDTH  (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hall_raw    (hall_raw),
        .hall_clean  (hall_clean),
        .rise_pulse  (rise_pulse),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled),
        .glitch_count(glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          valid;
        logic [7:0]  per;
    } rise_exp_t;

    rise_exp_t rise_q[$];
    int        stall_q[$];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_errors = 0;
    int        last_rise = 0;
    int        rel = 0;
    logic      stall_prev = 1'b0;
    rise_exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({hall_clean, rise_pulse, period, period_valid, stalled, glitch_count});
    endfunction

    // Raw pin sampled on the next edge; clean level appears FILT+2 edges after that.
    task automatic wave(input int n, input int per, input int hi, input bit v0, input int p0);
        rise_exp_t e;
        for (int i = 0; i < n; i++) begin
            hall_raw = 1'b1;
            e.cyc    = cyc + 1 + FILT + 2;
            e.valid  = (i == 0) ? v0 : 1'b1;
            e.per    = (i == 0) ? 8'(p0) : 8'(per);
            rise_q.push_back(e);
            last_rise = e.cyc;
            tick(hi);
            hall_raw = 1'b0;
            tick(per - hi);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((rise_q.size() != 0 || stall_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain", 32'(rise_q.size() + stall_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rise_pulse) begin
                check("rise_expected", 32'(rise_q.size() != 0), 1);
                if (rise_q.size() != 0) begin
                    mon_e = rise_q.pop_front();
                    check("rise_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("rise_pv", 32'(period_valid), 32'(mon_e.valid));
                    if (mon_e.valid) check("period", 32'(period), 32'(mon_e.per));
                    check("stall_clr", 32'(stalled), 0);
                end
            end
            if (period_valid) check("pv_needs_rise", 32'(rise_pulse), 1);
            if (stalled === 1'b1 && stall_prev !== 1'b1) begin
                check("stall_expected", 32'(stall_q.size() != 0), 1);
                if (stall_q.size() != 0) begin
                    check("stall_cycle", 32'(cyc), 32'(stall_q.pop_front()));
                    check("stall_period", 32'(period), 0);
                end
            end
        end
        stall_prev = stalled;
    end

    initial begin
        #500_000;
        n_errors++;
        $display("FAIL watchdog: got time limit, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        reset    = 1'b1;
        hall_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        rel   = cyc;

        // 1: idle after reset, stall at cycle TO
        check("reset_state", all_outs(), 0);
        stall_q.push_back(rel + TO);
        for (int k = 1; k < TO; k++) begin
            tick(1);
            check("idle_zero", all_outs(), 0);
        end
        wait_drain(20);
        check("idle_stalled", 32'(stalled), 1);

        // 2: short pulses rejected, counter saturates
        for (int g = 1; g <= 300; g++) begin
            hall_raw = 1'b1;
            tick(3);
            hall_raw = 1'b0;
            tick(8);
            if (g == 1 || g == 254 || g == 255 || g == 300)
                check("glitch_count", 32'(glitch_count), 32'((g > 255) ? 255 : g));
        end
        check("glitch_clean", 32'(hall_clean), 0);

        // 3: first rise unmeasured, second gives 40
        wave(2, 40, 20, 1'b0, 0);
        check("clean_low", 32'(hall_clean), 0);

        // 4: stall after last rise, then recover
        stall_q.push_back(last_rise + TO);
        wait_drain(150);
        wave(2, 40, 20, 1'b0, 0);

        // 5: rises exactly TO apart never stall
        wave(4, 100, 20, 1'b1, 40);

        // 6: reset 20 cycles into a measurement
        begin
            rise_exp_t e;
            hall_raw = 1'b1;
            e.cyc    = cyc + 1 + FILT + 2;
            e.valid  = 1'b1;
            e.per    = 8'(TO);
            rise_q.push_back(e);
            tick(27);
        end
        check("pre_reset_period", 32'(period), TO);
        reset    = 1'b1;
        hall_raw = 1'b0;
        tick(1);
        reset = 1'b0;
        check("midreset_state", all_outs(), 0);
        check("midreset_queue", 32'(rise_q.size()), 0);
        wave(2, 40, 20, 1'b0, 0);
        stall_q.push_back(last_rise + TO);
        wait_drain(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
